// File: rtl/fetch_stage.sv
// PC + IF/ID register stage feeding a byte-addressed instruction memory.
// Optional build macro FETCH_MISALIGN_TRAP_EN: trap on misaligned branch targets instead of masking.
module fetch_stage #(
  parameter int unsigned          ADDR_W    = 8,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter int unsigned          PC_STEP   = 4,
  parameter logic [DATA_W-1:0]    HALT_WORD = '1,
  parameter logic [DATA_W-1:0]    NOP_WORD  = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] direccion_o,
  input  logic [DATA_W-1:0] instruccion_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [ADDR_W-1:0] if_pc_plus4_o,
  output logic [DATA_W-1:0] if_instr_o,
  output logic              if_valid_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  instr_count_o,
  output logic              misalign_trap_o
);

  typedef enum logic [1:0] {StWarm, StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [ADDR_W-1:0] if_pc4_q, if_pc4_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + ADDR_W'(PC_STEP);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic misaligned;
  assign misaligned = (branch_target_i[1:0] != 2'b00);
`else
  logic [ADDR_W-1:0] tgt_aligned;
  assign tgt_aligned = branch_target_i & ~ADDR_W'(3);
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    cnt_d      = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d     = trap_q;
`endif
    case (state_q)
      StWarm: state_d = StRun;
      StRun: begin
        if (branch_taken_i) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_WORD;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misaligned) begin
            trap_d  = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d = branch_target_i;
          end
`else
          pc_d = tgt_aligned;
`endif
        end else if (stall_i) begin
          // PC holds; a concurrent flush still squashes the IF/ID slot
          if (flush_i) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_WORD;
          end
        end else if (flush_i) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_WORD;
          pc_d       = pc_inc;
        end else begin
          if_pc_d    = pc_q;
          if_pc4_d   = pc_inc;
          if_instr_d = instruccion_i;
          if_valid_d = 1'b1;
          cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          // HALT word is delivered to decode but PC stays parked on it
          if (instruccion_i == HALT_WORD) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StHalt: begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_WORD;
      end
      default: state_d = StWarm;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StWarm;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_pc4_q   <= '0;
      if_instr_q <= NOP_WORD;
      if_valid_q <= 1'b0;
      cnt_q      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      cnt_q      <= cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= trap_d;
`endif
    end
  end

  assign direccion_o   = pc_q;
  assign if_pc_o       = if_pc_q;
  assign if_pc_plus4_o = if_pc4_q;
  assign if_instr_o    = if_instr_q;
  assign if_valid_o    = if_valid_q;
  assign halted_o      = (state_q == StHalt);
  assign instr_count_o = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap_o = trap_q;
`else
  assign misalign_trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural fetch model checked every cycle, plus literal pins.
module tb_fetch_stage;

  localparam logic [31:0] WA   = 32'h1234_5678;
  localparam logic [31:0] WB   = 32'h9ABC_DEF0;
  localparam logic [31:0] WC   = 32'h0BAD_F00D;
  localparam logic [31:0] WD   = 32'hCAFE_BABE;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        bt = 1'b0;
  logic [7:0]  tgt = 8'h00;
  logic [7:0]  direccion;
  logic [31:0] instruccion;
  logic [7:0]  if_pc, if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid, halted, trap;
  logic [15:0] instr_count;

  logic [7:0]  mem [256];

  int n_pass = 0;
  int n_total = 0;

  fetch_stage dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_taken_i  (bt),
    .branch_target_i (tgt),
    .direccion_o     (direccion),
    .instruccion_i   (instruccion),
    .if_pc_o         (if_pc),
    .if_pc_plus4_o   (if_pc_plus4),
    .if_instr_o      (if_instr),
    .if_valid_o      (if_valid),
    .halted_o        (halted),
    .instr_count_o   (instr_count),
    .misalign_trap_o (trap)
  );

  always #5 clk = ~clk;

  // Big-endian combinational memory read
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = direccion;
    a1 = direccion + 8'd1;
    a2 = direccion + 8'd2;
    a3 = direccion + 8'd3;
    instruccion = {mem[a0], mem[a1], mem[a2], mem[a3]};
  end

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
  endfunction

  task automatic wr_word(input logic [7:0] a, input logic [31:0] w);
    mem[a]             = w[31:24];
    mem[8'(a + 8'd1)]  = w[23:16];
    mem[8'(a + 8'd2)]  = w[15:8];
    mem[8'(a + 8'd3)]  = w[7:0];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: mode 0 = warming up, 1 = fetching, 2 = halted
  int          m_mode;
  bit          m_live = 0;
  logic [7:0]  m_pc, m_if_pc, m_if_pc4;
  logic [31:0] m_instr;
  bit          m_valid, m_trap;
  int          m_cnt;

  always @(posedge clk) begin
    logic [31:0] w;
    if (reset) begin
      m_live = 1; m_mode = 0; m_pc = 8'h00; m_if_pc = 8'h00; m_if_pc4 = 8'h00;
      m_instr = NOP; m_valid = 0; m_trap = 0; m_cnt = 0;
    end else if (m_live) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 2) begin
        m_valid = 0; m_instr = NOP;
      end else if (bt) begin
        m_valid = 0; m_instr = NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (tgt % 4 != 0) begin m_trap = 1; m_mode = 2; end
        else m_pc = tgt;
`else
        m_pc = tgt - (tgt % 4);
`endif
      end else if (stall) begin
        if (flush) begin m_valid = 0; m_instr = NOP; end
      end else if (flush) begin
        m_valid = 0; m_instr = NOP; m_pc = 8'(m_pc + 4);
      end else begin
        w = rd_word(m_pc);
        m_if_pc = m_pc; m_if_pc4 = 8'(m_pc + 4); m_instr = w; m_valid = 1;
        if (m_cnt < 65535) m_cnt++;
        if (w == HALT) m_mode = 2;
        else m_pc = 8'(m_pc + 4);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("direccion", 64'(direccion), 64'(m_pc));
      chk("if_pc", 64'(if_pc), 64'(m_if_pc));
      chk("if_pc_plus4", 64'(if_pc_plus4), 64'(m_if_pc4));
      chk("if_instr", 64'(if_instr), 64'(m_instr));
      chk("if_valid", 64'(if_valid), 64'(m_valid));
      chk("halted", 64'(halted), 64'(m_mode == 2));
      chk("instr_count", 64'(instr_count), 64'(m_cnt));
      chk("misalign_trap", 64'(trap), 64'(m_trap));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] pc_before;
    for (int i = 0; i < 256; i += 4) wr_word(8'(i), {8'hC0, 8'(i), ~8'(i), 8'h5A});
    wr_word(8'h00, WA); wr_word(8'h04, WB); wr_word(8'h08, WC); wr_word(8'h0C, WD);

    cyc(2);
    reset = 1'b0;
    chk("lit_reset_valid", 64'(if_valid), 64'd0);
    chk("lit_reset_instr", 64'(if_instr), 64'(NOP));
    cyc(1);
    chk("lit_warm_valid", 64'(if_valid), 64'd0);
    chk("lit_warm_pc", 64'(direccion), 64'h00);
    cyc(1);
    chk("lit_A", 64'(if_instr), 64'(WA));
    chk("lit_A_pc", 64'(if_pc), 64'h00);
    cyc(1);
    chk("lit_B", 64'(if_instr), 64'(WB));

    stall = 1'b1;
    cyc(3);
    chk("lit_stall_instr", 64'(if_instr), 64'(WB));
    chk("lit_stall_pc", 64'(direccion), 64'h08);
    stall = 1'b0;
    cyc(1);
    chk("lit_C", 64'(if_instr), 64'(WC));
    chk("lit_C_pc", 64'(if_pc), 64'h08);
    cyc(1);
    chk("lit_D_pc", 64'(if_pc), 64'h0C);
    chk("lit_count4", 64'(instr_count), 64'd4);

    stall = 1'b1; bt = 1'b1; tgt = 8'h20;
    cyc(1);
    chk("lit_br_pc", 64'(direccion), 64'h20);
    chk("lit_br_valid", 64'(if_valid), 64'd0);
    stall = 1'b0; bt = 1'b0;
    cyc(1);
    chk("lit_br_ifpc", 64'(if_pc), 64'h20);
    chk("lit_br_valid2", 64'(if_valid), 64'd1);

    flush = 1'b1;
    cyc(1);
    chk("lit_flush_pc", 64'(direccion), 64'h28);
    chk("lit_flush_valid", 64'(if_valid), 64'd0);
    stall = 1'b1;
    cyc(1);
    chk("lit_flush_stall_pc", 64'(direccion), 64'h28);
    stall = 1'b0; flush = 1'b0;
    cyc(2);

    bt = 1'b1; tgt = 8'hFC;
    cyc(1);
    bt = 1'b0;
    cyc(1);
    chk("lit_wrap_pc", 64'(if_pc), 64'hFC);
    chk("lit_wrap_pc4", 64'(if_pc_plus4), 64'h00);
    cyc(1);
    chk("lit_wrap_next", 64'(if_pc), 64'h00);
    cyc(1);

    pc_before = direccion;
    bt = 1'b1; tgt = 8'h22;
    cyc(1);
    bt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("lit_mis_trap", 64'(trap), 64'd1);
    chk("lit_mis_halt", 64'(halted), 64'd1);
    chk("lit_mis_pc", 64'(direccion), 64'(pc_before));
`else
    chk("lit_mis_pc", 64'(direccion), 64'h20);
    chk("lit_mis_trap", 64'(trap), 64'd0);
`endif
    cyc(2);

    // HALT word at 0x08
    reset = 1'b1;
    wr_word(8'h08, HALT);
    cyc(1);
    reset = 1'b0;
    cyc(4);
    chk("lit_halt_instr", 64'(if_instr), 64'(HALT));
    chk("lit_halt_valid", 64'(if_valid), 64'd1);
    cyc(1);
    chk("lit_halted", 64'(halted), 64'd1);
    chk("lit_halted_valid", 64'(if_valid), 64'd0);
    chk("lit_halted_pc", 64'(direccion), 64'h08);
    bt = 1'b1; tgt = 8'h40; flush = 1'b1;
    cyc(2);
    bt = 1'b0; flush = 1'b0;
    chk("lit_halt_branch_pc", 64'(direccion), 64'h08);
    chk("lit_halt_count", 64'(instr_count), 64'd3);

    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("lit_recover_halt", 64'(halted), 64'd0);
    cyc(2);
    chk("lit_recover_A", 64'(if_instr), 64'(WA));
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
